// File: rtl/axis_frame_fifo_arbiter.sv
// Frame-granular round-robin arbiter in front of an axis_frame_fifo write port.
// Holds a grant from the first beat to tlast and aborts frames that stall mid-way.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   input_axis_*        S_COUNT packed AXI-stream sources (tdata/tvalid/tready/tlast/tuser)
//   output_axis_*       single AXI-stream toward the FIFO
//   grant               one-hot current owner, zero when idle
//   abort               one-cycle pulse after a hung frame was force-terminated
module axis_frame_fifo_arbiter #(
    parameter int S_COUNT    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0]   input_axis_tdata,
    input  logic [S_COUNT-1:0]              input_axis_tvalid,
    output logic [S_COUNT-1:0]              input_axis_tready,
    input  logic [S_COUNT-1:0]              input_axis_tlast,
    input  logic [S_COUNT-1:0]              input_axis_tuser,
    output logic [DATA_WIDTH-1:0]           output_axis_tdata,
    output logic                            output_axis_tvalid,
    input  logic                            output_axis_tready,
    output logic                            output_axis_tlast,
    output logic                            output_axis_tuser,
    output logic [S_COUNT-1:0]              grant,
    output logic                            abort
);

    localparam int IW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ABORT,
        DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [S_COUNT-1:0]   grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 abort_q, abort_d;

    logic                  sel_valid;
    logic                  sel_last;
    logic                  sel_user;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  pick_found;
    logic [IW-1:0]         pick_idx;
    logic [IW-1:0]         gnext;

    // Signals of the currently granted source.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (gidx_q == IW'(i)) begin
                sel_valid = input_axis_tvalid[i];
                sel_last  = input_axis_tlast[i];
                sel_user  = input_axis_tuser[i];
                sel_data  = input_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin pick: first search at/after the pointer, then wrap
    // around to the lowest-numbered requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (!pick_found && input_axis_tvalid[i] && IW'(i) >= rr_q) begin
                pick_found = 1'b1;
                pick_idx   = IW'(i);
            end
        end
        for (int i = 0; i < S_COUNT; i++) begin
            if (!pick_found && input_axis_tvalid[i]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(i);
            end
        end
    end

    assign gnext = (gidx_q == IW'(S_COUNT - 1)) ? '0 : gidx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = ACTIVE;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    for (int i = 0; i < S_COUNT; i++) begin
                        grant_d[i] = (pick_idx == IW'(i));
                    end
                end
            end
            ACTIVE: begin
                if (sel_valid && output_axis_tready) begin
                    cnt_d = '0;
                    if (sel_last) begin
                        state_d = IDLE;
                        grant_d = '0;
                        rr_d    = gnext;
                    end
                end else if (!sel_valid && TIMEOUT != 0) begin
                    // Only a silent source counts; FIFO backpressure does not.
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = ABORT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ABORT: begin
                if (output_axis_tready) begin
                    state_d = DRAIN;
                    abort_d = 1'b1;
                end
            end
            DRAIN: begin
                if (sel_valid && sel_last) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rr_d    = gnext;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        output_axis_tdata  = '0;
        output_axis_tvalid = 1'b0;
        output_axis_tlast  = 1'b0;
        output_axis_tuser  = 1'b0;
        input_axis_tready  = '0;
        unique case (state_q)
            ACTIVE: begin
                output_axis_tdata  = sel_data;
                output_axis_tvalid = sel_valid;
                output_axis_tlast  = sel_last;
                output_axis_tuser  = sel_user;
                input_axis_tready  = grant_q & {S_COUNT{output_axis_tready}};
            end
            ABORT: begin
                // Terminating beat marks the partial frame bad for the FIFO.
                output_axis_tvalid = 1'b1;
                output_axis_tlast  = 1'b1;
                output_axis_tuser  = 1'b1;
            end
            DRAIN: begin
                input_axis_tready = grant_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    assign grant = grant_q;
    assign abort = abort_q;

endmodule

// File: tb/tb_axis_frame_fifo_arbiter.sv
// Self-checking bench for axis_frame_fifo_arbiter.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_axis_frame_fifo_arbiter;

    localparam int S  = 3;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [S*DW-1:0] s_data;
    logic [S-1:0]    s_valid, s_ready, s_last, s_user;
    logic [DW-1:0]   o_data;
    logic            o_valid, o_ready, o_last, o_user;
    logic [S-1:0]    grant;
    logic            abort;

    axis_frame_fifo_arbiter #(
        .S_COUNT(S), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .input_axis_tdata(s_data), .input_axis_tvalid(s_valid),
        .input_axis_tready(s_ready), .input_axis_tlast(s_last),
        .input_axis_tuser(s_user),
        .output_axis_tdata(o_data), .output_axis_tvalid(o_valid),
        .output_axis_tready(o_ready), .output_axis_tlast(o_last),
        .output_axis_tuser(o_user),
        .grant(grant), .abort(abort)
    );

    // Second instance with the watchdog disabled.
    logic [2*DW-1:0] b_data;
    logic [1:0]      b_valid, b_ready, b_last, b_user, b_grant;
    logic [DW-1:0]   bo_data;
    logic            bo_valid, bo_ready, bo_last, bo_user, b_abort;

    axis_frame_fifo_arbiter #(
        .S_COUNT(2), .DATA_WIDTH(DW), .TIMEOUT(0)
    ) dut_nt (
        .clk(clk), .rst(rst),
        .input_axis_tdata(b_data), .input_axis_tvalid(b_valid),
        .input_axis_tready(b_ready), .input_axis_tlast(b_last),
        .input_axis_tuser(b_user),
        .output_axis_tdata(bo_data), .output_axis_tvalid(bo_valid),
        .output_axis_tready(bo_ready), .output_axis_tlast(bo_last),
        .output_axis_tuser(bo_user),
        .grant(b_grant), .abort(b_abort)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got_v,
                       input logic [31:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    // Behavioural model: who owns the output and what it is doing.
    // mode 0 = nobody, 1 = forwarding, 2 = forcing bad tail, 3 = sinking.
    int   mode    = 0;
    int   owner   = 0;
    int   ptr     = 0;
    int   stall   = 0;
    logic m_abort = 1'b0;
    logic chk_en  = 1'b0;
    int   n_abort = 0;
    logic [9:0] got[$];

    typedef struct {
        logic [S-1:0]  rdy;
        logic          v, l, u;
        logic [DW-1:0] d;
        logic [S-1:0]  g;
        logic          ab;
    } exp_t;

    function automatic logic bit_at(input logic [S-1:0] v, input int i);
        return ((v >> i) & S'(1)) != '0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.rdy = '0; e.v = 1'b0; e.l = 1'b0; e.u = 1'b0;
        e.d = '0; e.g = '0; e.ab = m_abort;
        if (mode != 0) e.g = S'(1) << owner;
        case (mode)
            1: begin
                e.v   = bit_at(s_valid, owner);
                e.l   = bit_at(s_last, owner);
                e.u   = bit_at(s_user, owner);
                e.d   = DW'(s_data >> (owner * DW));
                e.rdy = o_ready ? (S'(1) << owner) : '0;
            end
            2: begin
                e.v = 1'b1; e.l = 1'b1; e.u = 1'b1;
            end
            3: e.rdy = S'(1) << owner;
            default: ;
        endcase
        return e;
    endfunction

    always @(posedge clk) begin : model_blk
        logic ab, v, l;
        ab = 1'b0;
        v  = bit_at(s_valid, owner);
        l  = bit_at(s_last, owner);
        if (rst) begin
            mode = 0; owner = 0; ptr = 0; stall = 0;
        end else begin
            case (mode)
                0: for (int k = 0; k < S; k++) begin
                    int j;
                    j = (ptr + k) % S;
                    if (mode == 0 && bit_at(s_valid, j)) begin
                        owner = j; mode = 1; stall = 0;
                    end
                end
                1: begin
                    if (v && o_ready) begin
                        stall = 0;
                        if (l) begin
                            mode = 0; ptr = (owner + 1) % S;
                        end
                    end else if (!v) begin
                        stall++;
                        if (TO != 0 && stall >= TO) mode = 2;
                    end
                end
                2: if (o_ready) begin
                    mode = 3; ab = 1'b1;
                end
                3: if (v && l) begin
                    mode = 0; ptr = (owner + 1) % S;
                end
                default: ;
            endcase
        end
        m_abort = ab;
    end

    always @(negedge clk) begin : chk_blk
        exp_t e;
        if (chk_en) begin
            e = model_out();
            chk("grant", grant, e.g);
            chk("tready", s_ready, e.rdy);
            chk("tvalid", o_valid, e.v);
            chk("tlast", o_last, e.l);
            chk("tuser", o_user, e.u);
            chk("tdata", o_data, e.d);
            chk("abort", abort, e.ab);
            if (abort) n_abort++;
            if (o_valid && o_ready) got.push_back({o_user, o_last, o_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int src, input logic [DW-1:0] d,
                       input logic l, input logic u);
        exp_t e;
        logic ok;
        ok = 1'b0;
        s_data[src*DW +: DW] = d;
        s_last  = (s_last & ~(S'(1) << src)) | (S'(l) << src);
        s_user  = (s_user & ~(S'(1) << src)) | (S'(u) << src);
        s_valid = s_valid | (S'(1) << src);
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            e  = model_out();
            ok = bit_at(e.rdy, src);
        end
        chk("handshake", ok, 1);
        step();
        s_valid = s_valid & ~(S'(1) << src);
        s_last  = s_last & ~(S'(1) << src);
        s_user  = s_user & ~(S'(1) << src);
    endtask

    task automatic frame(input int src, input int n, input logic [DW-1:0] base);
        for (int b = 0; b < n; b++) put(src, base + DW'(b), b == n - 1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin : main
        logic [DW-1:0] t2_exp[8];
        int   left[S];
        int   pause[S];
        logic [S-1:0] acc;
        exp_t e;
        logic ok;
        logic [DW-1:0] d1;
        logic l1;
        int held, nab;

        rst = 1'b1;
        s_data = '0; s_valid = '0; s_last = '0; s_user = '0;
        o_ready = 1'b1;
        b_data = '0; b_valid = '0; b_last = '0; b_user = '0;
        bo_ready = 1'b1;
        chk_en = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_tready", s_ready, 0);
        chk("rst_tvalid", o_valid, 0);
        chk("rst_abort", abort, 0);
        step();
        rst = 1'b0;

        // Single 3-beat frame from source 0.
        got.delete();
        frame(0, 3, 8'h01);
        step();
        @(negedge clk);
        chk("t1_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("t1_beat0", got[0], 10'h001);
            chk("t1_beat1", got[1], 10'h002);
            chk("t1_beat2", got[2], 10'h103);
        end
        chk("t1_grant_after", grant, 0);

        // Two contests between sources 0 and 1 from reset.
        do_reset();
        got.delete();
        fork
            frame(0, 2, 8'h20);
            frame(1, 2, 8'h30);
        join
        fork
            frame(0, 2, 8'h24);
            frame(1, 2, 8'h34);
        join
        step();
        t2_exp = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h24, 8'h25, 8'h34, 8'h35};
        chk("t2_count", got.size(), 8);
        if (got.size() == 8)
            for (int i = 0; i < 8; i++) chk("t2_order", got[i][7:0], t2_exp[i]);

        // Mid-frame stall on source 1 triggers the watchdog.
        got.delete();
        n_abort = 0;
        put(1, 8'h11, 1'b0, 1'b0);
        repeat (25) step();
        chk("t3_abort_pulses", n_abort, 1);
        chk("t3_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t3_first", got[0], 10'h011);
            chk("t3_forced", got[1], 10'h300);
        end
        frame(1, 2, 8'h12);
        step();
        @(negedge clk);
        chk("t3_sunk", got.size(), 2);
        chk("t3_grant_after", grant, 0);

        // Long FIFO backpressure mid-frame must not abort.
        got.delete();
        n_abort = 0;
        fork
            frame(2, 4, 8'h40);
            begin
                repeat (3) step();
                o_ready = 1'b0;
                repeat (40) step();
                o_ready = 1'b1;
            end
        join
        step();
        chk("t4_no_abort", n_abort, 0);
        chk("t4_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("t4_beat0", got[0], 10'h040);
            chk("t4_beat3", got[3], 10'h143);
        end

        // Reset in the middle of a frame from source 2.
        put(2, 8'h50, 1'b0, 1'b0);
        put(2, 8'h51, 1'b0, 1'b0);
        s_data[2*DW +: DW] = 8'h52;
        s_valid = 3'b100;
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_valid = '0;
        @(negedge clk);
        chk("t5_grant", grant, 0);
        chk("t5_tready", s_ready, 0);
        chk("t5_tvalid", o_valid, 0);
        step();
        got.delete();
        fork
            frame(2, 1, 8'h60);
            frame(0, 1, 8'h61);
        join
        step();
        chk("t5_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t5_first", got[0], 10'h161);
            chk("t5_second", got[1], 10'h160);
        end

        // Watchdog disabled: 100-cycle stall keeps the grant.
        b_data[DW-1:0] = 8'h71;
        b_valid = 2'b01;
        ok = 1'b0; d1 = '0; l1 = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (b_ready[0]) begin
                ok = 1'b1; d1 = bo_data;
            end
        end
        chk("t6_hs1", ok, 1);
        chk("t6_beat1", d1, 8'h71);
        step();
        b_valid = '0;
        held = 0; nab = 0;
        repeat (100) begin
            @(negedge clk);
            if (b_grant == 2'b01) held++;
            if (b_abort) nab++;
        end
        chk("t6_grant_held", held, 100);
        chk("t6_no_abort", nab, 0);
        step();
        b_data[DW-1:0] = 8'h72;
        b_last = 2'b01;
        b_valid = 2'b01;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (b_ready[0]) begin
                ok = 1'b1; d1 = bo_data; l1 = bo_last;
            end
        end
        chk("t6_hs2", ok, 1);
        chk("t6_beat2", d1, 8'h72);
        chk("t6_last", l1, 1);
        step();
        b_valid = '0;
        b_last = '0;
        @(negedge clk);
        chk("t6_grant_after", b_grant, 0);
        step();

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < S; i++) begin
            left[i] = 0; pause[i] = 0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            e = model_out();
            acc = s_valid & e.rdy;
            step();
            rst = ($urandom_range(0, 599) == 0);
            o_ready = ($urandom_range(0, 99) < 75);
            for (int i = 0; i < S; i++) begin
                if (bit_at(acc, i)) begin
                    s_valid = s_valid & ~(S'(1) << i);
                    left[i]--;
                end
                if (!bit_at(s_valid, i)) begin
                    if (pause[i] > 0) begin
                        pause[i]--;
                    end else if ($urandom_range(0, 39) == 0) begin
                        pause[i] = $urandom_range(5, 24);
                    end else if ($urandom_range(0, 99) < 60) begin
                        if (left[i] <= 0) left[i] = $urandom_range(1, 5);
                        s_data[i*DW +: DW] = DW'($urandom);
                        s_last = (s_last & ~(S'(1) << i)) |
                                 (S'(left[i] == 1) << i);
                        s_user = (s_user & ~(S'(1) << i)) |
                                 (S'($urandom_range(0, 7) == 0) << i);
                        s_valid = s_valid | (S'(1) << i);
                    end
                end
            end
        end
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
